display_scan_controller: RTL

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It takes the packed segment patterns produced by the hex-to-seven-segment decoder, double-buffers them, and drives one shared 7-bit segment bus plus one active-low anode per digit, one digit at a time. A fixed blanking interval at the start of each digit slot suppresses ghosting. Frame-boundary buffer swaps give tear-free updates. It sits between the decoder and the board pins.

---
 rtl/display_scan_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// Multiplexed common-anode seven-segment scan controller with a double-buffered
// pattern store. Each digit slot starts with a short blanking phase to prevent ghosting.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BLANK | slot offset < BLANK_CYCLES, all anodes off, segments dark
// ST_DRIVE | rest of the slot, drive current digit if enabled
module display_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS*7-1:0] seg_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
  localparam state_e ST_INIT = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [NUM_DIGITS*7-1:0] pending_q, pending_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS*7-1:0] active_q, active_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;
  logic                    slot_last, digit_last, frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      slot_q       <= '0;
      digit_q      <= '0;
      pending_q    <= '1;
      pend_valid_q <= 1'b0;
      active_q     <= '1;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      digit_q      <= digit_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    slot_last  = (slot_q == SLOT_W'(REFRESH_DIV - 1));
    digit_last = (digit_q == DIG_W'(NUM_DIGITS - 1));
    frame_end  = slot_last && digit_last;

    slot_d  = slot_last ? '0 : slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_last) digit_d = digit_last ? '0 : digit_q + 1'b1;

    // Phase is decoded from the position being entered, so it lines up with slot_d.
    state_d = (int'(slot_d) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;

    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    if (load) begin
      pending_d    = seg_in;
      pend_valid_d = 1'b1;
    end
    // A load coinciding with the frame boundary bypasses the pending buffer.
    if (frame_end) begin
      if (load) begin
        active_d     = seg_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        active_d     = pending_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    an_d         = '1;
    seg_d        = 7'h7F;
    frame_done_d = frame_end;
    if (state_q == ST_DRIVE && digit_en[digit_q]) begin
      an_d[digit_q] = 1'b0;
      seg_d         = active_q[int'(digit_q)*7 +: 7];
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
